// File: rtl/alu_result_buffer.sv
// FWFT capture FIFO for the subtractor result stream, with head-zero flag and a saturating drop counter.
// Optional build macro ALU_RESBUF_DEDUP_EN: discards an input equal to the last word pushed.
module alu_result_buffer #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DW-1:0]              in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic                       out_zero,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic push;
  logic pop;
  logic drop;
  logic dup;

  // Status flags are decoded straight from the occupancy flop so an async reset shows up at once.
  assign empty     = (count_q == '0);
  assign full      = (count_q == COUNT_FULL);
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign out_zero  = out_valid && (out_data == '0);
  assign count     = count_q;
  assign drop_cnt  = drop_cnt_q;

  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop) && !dup;
  assign drop = in_valid && full && !pop && !dup;

`ifdef ALU_RESBUF_DEDUP_EN
  logic [DW-1:0] last_val_q, last_val_d;
  logic          last_ok_q, last_ok_d;

  assign dup = in_valid && last_ok_q && (in_data == last_val_q);

  always_comb begin
    last_val_d = last_val_q;
    last_ok_d  = last_ok_q;
    if (push) begin
      last_val_d = in_data;
      last_ok_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_val_q <= '0;
      last_ok_q  <= 1'b0;
    end else begin
      last_val_q <= last_val_d;
      last_ok_q  <= last_ok_d;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is left unreset; empty masks its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: vector table plus hand sequences for overflow, reset and saturation.
module tb_alu_result_buffer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_zero;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

`ifdef ALU_RESBUF_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  alu_result_buffer #(.DEPTH(8), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       r;
    int         cnt;
    logic       ov;
    logic [7:0] od;
    logic       oz;
    logic       fl;
    int         drop;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(logic v, logic [7:0] d, logic r, int cnt, logic [7:0] od,
                              logic oz);
    vec_t x;
    x.v = v; x.d = d; x.r = r; x.cnt = cnt;
    x.ov = (cnt != 0); x.od = od; x.oz = oz; x.fl = (cnt == 8); x.drop = 0;
    return x;
  endfunction

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs for one cycle are driven 1 ns after a rising edge; results sampled 1 ns after the next.
  task automatic step(logic v, logic [7:0] d, logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
  endtask

  initial begin
    // fill/drain
    vecs[0]  = mk(1, 8'h03, 0, 1, 8'h03, 0);
    vecs[1]  = mk(1, 8'h05, 0, 2, 8'h03, 0);
    vecs[2]  = mk(1, 8'h07, 0, 3, 8'h03, 0);
    vecs[3]  = mk(0, 8'h00, 1, 2, 8'h05, 0);
    vecs[4]  = mk(0, 8'h00, 1, 1, 8'h07, 0);
    vecs[5]  = mk(0, 8'h00, 1, 0, 8'h00, 0);
    vecs[6]  = mk(0, 8'h00, 1, 0, 8'h00, 0);
    // zero flag; push+pop while empty only pushes
    vecs[7]  = mk(1, 8'h00, 1, 1, 8'h00, 1);
    vecs[8]  = mk(1, 8'h01, 0, 2, 8'h00, 1);
    vecs[9]  = mk(0, 8'h00, 1, 1, 8'h01, 0);
    vecs[10] = mk(0, 8'h00, 1, 0, 8'h00, 0);
    // repeated values
    vecs[11] = mk(1, 8'h04, 0, 1, 8'h04, 0);
    vecs[12] = mk(1, 8'h04, 0, DEDUP ? 1 : 2, 8'h04, 0);
    vecs[13] = mk(1, 8'h04, 0, DEDUP ? 1 : 3, 8'h04, 0);
    vecs[14] = mk(1, 8'h02, 0, DEDUP ? 2 : 4, 8'h04, 0);
    vecs[15] = mk(0, 8'h00, 1, DEDUP ? 1 : 3, DEDUP ? 8'h02 : 8'h04, 0);
    vecs[16] = mk(0, 8'h00, 1, DEDUP ? 0 : 2, 8'h04, 0);
    vecs[17] = mk(0, 8'h00, 1, DEDUP ? 0 : 1, 8'h02, 0);
    vecs[18] = mk(0, 8'h00, 1, 0, 8'h00, 0);
    // last value survives the FIFO going empty
    vecs[19] = mk(1, 8'h02, 0, DEDUP ? 0 : 1, 8'h02, 0);
    vecs[20] = mk(0, 8'h00, 1, 0, 8'h00, 0);

    idle();
    rst_n = 1'b1;
    #12;
    rst_n = 1'b0;
    #1;
    check("reset_empty", empty, 1);
    check("reset_count", count, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_drop", drop_cnt, 0);
    check("reset_full", full, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].v, vecs[i].d, vecs[i].r);
      check($sformatf("vec%0d_count", i), count, vecs[i].cnt);
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ov);
      check($sformatf("vec%0d_empty", i), empty, !vecs[i].ov);
      check($sformatf("vec%0d_full", i), full, vecs[i].fl);
      check($sformatf("vec%0d_out_zero", i), out_zero, vecs[i].oz);
      check($sformatf("vec%0d_drop", i), drop_cnt, vecs[i].drop);
      if (vecs[i].ov) check($sformatf("vec%0d_out_data", i), out_data, vecs[i].od);
    end

    // overflow: 10 distinct pushes with no consumer
    for (int i = 0; i < 10; i++) step(1, 8'h10 + 8'(i), 0);
    check("ovf_full", full, 1);
    check("ovf_count", count, 8);
    check("ovf_drop", drop_cnt, 2);
    check("ovf_head", out_data, 8'h10);

    // push and pop together while full
    step(1, 8'h0A, 1);
    check("fullpp_count", count, 8);
    check("fullpp_drop", drop_cnt, 2);
    check("fullpp_full", full, 1);
    check("fullpp_head", out_data, 8'h11);

    // drop counter saturation: 253 more rejected writes reach 255, then hold
    for (int i = 0; i < 253; i++) step(1, 8'hEE, 0);
    check("sat_drop_255", drop_cnt, 255);
    step(1, 8'hEE, 0);
    step(1, 8'hEE, 0);
    check("sat_drop_hold", drop_cnt, 255);
    check("sat_count", count, 8);

    // drain: 0x11..0x17 then 0x0A
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_data", i), out_data, (i < 7) ? (8'h11 + i) : 8'h0A);
      check($sformatf("drain%0d_valid", i), out_valid, 1);
      step(0, 8'h00, 1);
    end
    check("drain_empty", empty, 1);
    check("drain_count", count, 0);

    // mid-stream asynchronous reset discards buffered data
    step(1, 8'h33, 0);
    step(1, 8'h34, 0);
    check("pre_rst_count", count, 2);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    check("midrst_valid", out_valid, 0);
    check("midrst_drop", drop_cnt, 0);
    check("midrst_zero", out_zero, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_empty", empty, 1);
    check("postrst_count", count, 0);
    // dedup history was cleared too, so 0x34 is accepted again
    step(1, 8'h34, 0);
    check("postrst_push_count", count, 1);
    check("postrst_push_data", out_data, 8'h34);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
